// File: rtl/tt_um_down_timer_8bits.sv
// tt_um_down_timer_8bits
//   Programmable down-counting timer with a valid/ready load handshake,
//   one-shot and auto-reload modes, and a registered one-cycle
//   terminal-count pulse.
//
//   Optional build macro: TT_DOWN_TIMER_PRESCALE_EN
//     When defined, the count only steps on every PRESCALE-th enabled cycle.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   load_valid  in   start value offered
//   load_ready  out  load can be accepted (state != RUN)
//   load_value  in   [WIDTH] start / reload value
//   load_mode   in   0 = one-shot, 1 = auto-reload (sampled with load)
//   en          in   count enable
//   stop        in   synchronous abort while running
//   cnt         out  [WIDTH] current count
//   tc          out  terminal-count pulse
//   busy        out  state == RUN
//   done        out  state == DONE
module tt_um_down_timer_8bits #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             load_mode,
  input  logic             en,
  input  logic             stop,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] cnt_n;
  logic [WIDTH-1:0] reload, reload_n;
  logic             mode, mode_n;
  logic             tc_n;
  logic             step;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef TT_DOWN_TIMER_PRESCALE_EN
  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);
  logic [7:0] pre, pre_n;
  assign step = en && (pre == PRE_LAST);
`else
  assign step = en;
`endif

  assign busy       = (state == RUN);
  assign done       = (state == DONE);
  assign load_ready = (state != RUN);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    reload_n = reload;
    mode_n   = mode;
    tc_n     = 1'b0;
`ifdef TT_DOWN_TIMER_PRESCALE_EN
    pre_n    = pre;
`endif
    if (state == RUN) begin
      // stop wins over a coincident terminal count, so no tc is raised
      if (stop) begin
        state_n = IDLE;
        cnt_n   = '0;
`ifdef TT_DOWN_TIMER_PRESCALE_EN
        pre_n   = '0;
`endif
      end else begin
`ifdef TT_DOWN_TIMER_PRESCALE_EN
        if (en) pre_n = step ? '0 : pre + 8'd1;
`endif
        if (step) begin
          if (cnt == ONE) begin
            tc_n = 1'b1;
            if (mode) begin
              cnt_n = reload;
            end else begin
              cnt_n   = '0;
              state_n = DONE;
            end
          end else begin
            cnt_n = cnt - ONE;
          end
        end
      end
    end else if (load_valid) begin
      reload_n = load_value;
      mode_n   = load_mode;
      cnt_n    = load_value;
`ifdef TT_DOWN_TIMER_PRESCALE_EN
      pre_n    = '0;
`endif
      // a zero load completes immediately and never loops
      if (load_value == '0) begin
        state_n = DONE;
        tc_n    = 1'b1;
      end else begin
        state_n = RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      reload <= '0;
      mode   <= 1'b0;
      tc     <= 1'b0;
`ifdef TT_DOWN_TIMER_PRESCALE_EN
      pre    <= '0;
`endif
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      reload <= reload_n;
      mode   <= mode_n;
      tc     <= tc_n;
`ifdef TT_DOWN_TIMER_PRESCALE_EN
      pre    <= pre_n;
`endif
    end
  end

endmodule

// File: tb/tb_tt_um_down_timer_8bits.sv
// Directed testbench for tt_um_down_timer_8bits. Inputs change 1 ns after a
// rising edge; outputs are checked at that same point.
module tb_tt_um_down_timer_8bits;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_value;
  logic       load_mode;
  logic       en;
  logic       stop;
  logic [7:0] cnt;
  logic       tc;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  tt_um_down_timer_8bits #(.WIDTH(8), .PRESCALE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .load_mode  (load_mode),
    .en         (en),
    .stop       (stop),
    .cnt        (cnt),
    .tc         (tc),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v, input logic m);
    load_valid = 1'b1;
    load_value = v;
    load_mode  = m;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic outs(input string tag, input int c, input int t, input int b, input int d);
    check({tag, ".cnt"},  32'(cnt),  32'(c));
    check({tag, ".tc"},   32'(tc),   32'(t));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
  endtask

  initial begin
    // reset with random inputs
    rst_n      = 1'b0;
    load_valid = 1'($urandom);
    load_value = 8'($urandom);
    load_mode  = 1'($urandom);
    en         = 1'($urandom);
    stop       = 1'($urandom);
    repeat (3) tick();
    outs("rst", 0, 0, 0, 0);
    check("rst.ready", 32'(load_ready), 32'd1);
    load_valid = 1'b0; en = 1'b0; stop = 1'b0; load_value = '0; load_mode = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    outs("idle", 0, 0, 0, 0);

`ifdef TT_DOWN_TIMER_PRESCALE_EN
    // prescale 4, load 2: tc after 8 enabled cycles
    en = 1'b1;
    load(8'd2, 1'b0);
    outs("pre.ld", 2, 0, 1, 0);
    repeat (3) tick();
    outs("pre.c3", 2, 0, 1, 0);
    tick();
    outs("pre.c4", 1, 0, 1, 0);
    repeat (3) tick();
    outs("pre.c7", 1, 0, 1, 0);
    tick();
    outs("pre.c8", 0, 1, 0, 1);
`else
    // one-shot 5
    en = 1'b1;
    load(8'd5, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      outs($sformatf("os.%0d", i), 5 - i, (i == 5) ? 1 : 0, (i == 5) ? 0 : 1, (i == 5) ? 1 : 0);
      if (i < 5) tick();
    end
    check("os.ready", 32'(load_ready), 32'd1);
    tick();
    outs("os.after", 0, 0, 0, 1);

    // auto-reload 3, load attempts during the run are ignored
    load(8'd3, 1'b1);
    for (int k = 0; k <= 9; k++) begin
      outs($sformatf("ar.%0d", k), 3 - (k % 3), (k > 0 && k % 3 == 0) ? 1 : 0, 1, 0);
      if (k == 0) check("ar.ready", 32'(load_ready), 32'd0);
      load_valid = (k == 1 || k == 4);
      load_value = 8'd7;
      tick();
    end
    load_valid = 1'b0;
    // now cnt=2; one more step to cnt=1, then stop
    outs("ar.10", 2, 0, 1, 0);
    tick();
    outs("ar.11", 1, 0, 1, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    outs("stop", 0, 0, 0, 0);
    check("stop.ready", 32'(load_ready), 32'd1);
    tick();
    outs("stop.after", 0, 0, 0, 0);

    // enable held low at cnt=2 delays tc by 2 cycles
    load(8'd4, 1'b0);
    outs("hold.ld", 4, 0, 1, 0);
    tick();
    tick();
    outs("hold.2", 2, 0, 1, 0);
    en = 1'b0;
    tick();
    outs("hold.h1", 2, 0, 1, 0);
    tick();
    outs("hold.h2", 2, 0, 1, 0);
    en = 1'b1;
    tick();
    outs("hold.1", 1, 0, 1, 0);
    tick();
    outs("hold.0", 0, 1, 0, 1);

    // load 0 (auto-reload mode): immediate done, tc once, never busy
    load(8'd0, 1'b1);
    outs("zero.ld", 0, 1, 0, 1);
    tick();
    outs("zero.after", 0, 0, 0, 1);

    // auto-reload 1 with en high: tc stays high
    load(8'd1, 1'b1);
    outs("n1.ld", 1, 0, 1, 0);
    tick();
    outs("n1.a", 1, 1, 1, 0);
    tick();
    outs("n1.b", 1, 1, 1, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    outs("n1.stop", 0, 0, 0, 0);

    // asynchronous reset mid-run at cnt=2
    load(8'd3, 1'b0);
    tick();
    outs("ar_rst.pre", 2, 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    outs("ar_rst.now", 0, 0, 0, 0);
    check("ar_rst.ready", 32'(load_ready), 32'd1);
    tick();
    tick();
    outs("ar_rst.hold", 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    tick();
    outs("ar_rst.rel", 0, 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
